// File: rtl/out_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : out_buffer_pkg
//  Description : Shared types and constants for the output buffer. Holds the
//                FSM state encoding, default sizing for one 44x44 result map
//                and the MSB-first byte-strobe patterns.
//  Revision    : 1.0 - initial release
// ============================================================================
package out_buffer_pkg;

  localparam int unsigned C_RESULTS = 1936;  // result bytes per transfer
  localparam int unsigned C_DEPTH   = 484;   // words, ceil(C_RESULTS/4)
  localparam int unsigned C_AW      = 9;     // word RAM address width

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SEND    = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // Bytes are packed MSB-first, so a partial word fills strobes from bit 3 down.
  localparam logic [3:0] C_STRB_1 = 4'b1000;
  localparam logic [3:0] C_STRB_2 = 4'b1100;
  localparam logic [3:0] C_STRB_3 = 4'b1110;
  localparam logic [3:0] C_STRB_4 = 4'b1111;

  // Strobe for a word holding nbytes valid bytes; 0 means a full word.
  function automatic logic [3:0] strb_for(input logic [1:0] nbytes);
    case (nbytes)
      2'd1:    strb_for = C_STRB_1;
      2'd2:    strb_for = C_STRB_2;
      2'd3:    strb_for = C_STRB_3;
      default: strb_for = C_STRB_4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/out_word_ram.sv
`default_nettype none
// ============================================================================
//  Module      : out_word_ram
//  Description : Simple dual-port 32-bit word RAM, synchronous write and
//                registered (1-cycle) read. No reset on storage or read data.
//  Ports       : clk      - clock
//                we_i     - write enable, waddr_i/wdata_i - write port
//                re_i     - read enable,  raddr_i         - read address
//                rdata_o  - read data, valid the cycle after re_i
//  Revision    : 1.0 - initial release
// ============================================================================
module out_word_ram #(
  parameter int unsigned DEPTH = 484,
  parameter int unsigned AW    = 9
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/out_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : out_buffer
//  Description : Packs 8-bit PE results four per word into a word RAM and, on
//                a send request, streams the stored words (plus any partial
//                word) to the DMA as an AXI4-Stream master with tlast.
//  Ports       : clk, rstn (async active-low)
//                i_result/i_result_valid - result bytes from the PE path
//                i_send_flg              - pulse: collection complete
//                m_axis_*                - AXI4-Stream master
//                o_busy  - streaming, o_done - pulse after last beat,
//                o_err   - sticky dropped-byte flag
//  Revision    : 1.0 - initial release
// ============================================================================
module out_buffer
  import out_buffer_pkg::*;
#(
  parameter int unsigned RESULTS = C_RESULTS,
  parameter int unsigned DEPTH   = C_DEPTH,
  parameter int unsigned AW      = C_AW
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  i_result,
  input  logic        i_result_valid,
  input  logic        i_send_flg,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tstrb,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  // Pointers need one extra bit so wr_ptr can reach DEPTH.
  localparam int unsigned PW        = AW + 1;
  localparam int unsigned MAP_WORDS = (RESULTS + 3) / 4;
  localparam int unsigned CAP_WORDS = (DEPTH < MAP_WORDS) ? DEPTH : MAP_WORDS;
  localparam logic [PW-1:0] CAP     = PW'(CAP_WORDS);

  state_e        state_q;
  logic [PW-1:0] wr_ptr_q, beats_q, rd_idx_q;
  logic [1:0]    cnt_q;
  logic [23:0]   pack_q;     // first three bytes of the word being built
  logic          busy_q, done_q, err_q;

  // Read pipeline stage (RAM output or partial word), then output + skid.
  logic          rd_v_q, rd_part_q, rd_last_q;
  logic [31:0]   tdata_q, skid_data_q;
  logic [3:0]    tstrb_q, skid_strb_q;
  logic          tlast_q, tvalid_q, skid_last_q, skid_v_q;

  logic [31:0]   ram_rdata_w;

  // A byte coinciding with i_send_flg arrives after collection closed: dropped.
  logic accept_w, drop_w, wr_en_w, start_w;
  assign start_w  = (state_q == ST_COLLECT) && i_send_flg;
  assign accept_w = (state_q == ST_COLLECT) && i_result_valid && !i_send_flg &&
                    (wr_ptr_q < CAP);
  assign drop_w   = i_result_valid && !accept_w;
  assign wr_en_w  = accept_w && (cnt_q == 2'd3);

  logic [PW-1:0] beats_now_w, beats_w;
  assign beats_now_w = wr_ptr_q + {{(PW-1){1'b0}}, (cnt_q != 2'd0)};
  assign beats_w     = start_w ? beats_now_w : beats_q;

  // Stored + in-flight entries may never exceed the two slots (output, skid).
  logic       pop_w, space_w, issue_w, issue_part_w, issue_last_w;
  logic [1:0] occ_w;
  assign pop_w   = tvalid_q && m_axis_tready;
  assign occ_w   = {1'b0, tvalid_q} + {1'b0, skid_v_q} + {1'b0, rd_v_q};
  assign space_w = (occ_w - {1'b0, pop_w}) < 2'd2;
  assign issue_w = (start_w && (beats_now_w != '0)) ||
                   ((state_q == ST_SEND) && (rd_idx_q < beats_q) && space_w);
  assign issue_part_w = (rd_idx_q == wr_ptr_q);
  assign issue_last_w = (rd_idx_q == (beats_w - PW'(1)));

  logic [31:0] in_data_w;
  logic [3:0]  in_strb_w;
  assign in_data_w = rd_part_q ? {pack_q, 8'h00} : ram_rdata_w;
  assign in_strb_w = rd_part_q ? strb_for(cnt_q) : C_STRB_4;

  out_word_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en_w),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i ({pack_q, i_result}),
    .re_i    (issue_w && !issue_part_w),
    .raddr_i (rd_idx_q[AW-1:0]),
    .rdata_o (ram_rdata_w)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_COLLECT;
      wr_ptr_q    <= '0;
      beats_q     <= '0;
      rd_idx_q    <= '0;
      cnt_q       <= 2'd0;
      pack_q      <= 24'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_v_q      <= 1'b0;
      rd_part_q   <= 1'b0;
      rd_last_q   <= 1'b0;
      tdata_q     <= 32'h0;
      tstrb_q     <= 4'h0;
      tlast_q     <= 1'b0;
      tvalid_q    <= 1'b0;
      skid_data_q <= 32'h0;
      skid_strb_q <= 4'h0;
      skid_last_q <= 1'b0;
      skid_v_q    <= 1'b0;
    end else begin
      // Packer: byte 0 clears the low bytes so a partial flush is zero-padded.
      if (accept_w) begin
        case (cnt_q)
          2'd0:    pack_q       <= {i_result, 16'h0};
          2'd1:    pack_q[15:8] <= i_result;
          2'd2:    pack_q[7:0]  <= i_result;
          default: ;
        endcase
        cnt_q <= cnt_q + 2'd1;
        if (cnt_q == 2'd3) wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (drop_w) err_q <= 1'b1;

      rd_v_q <= issue_w;
      if (issue_w) begin
        rd_part_q <= issue_part_w;
        rd_last_q <= issue_last_w;
        rd_idx_q  <= rd_idx_q + PW'(1);
      end

      if (pop_w) begin
        if (skid_v_q) begin
          tdata_q     <= skid_data_q;
          tstrb_q     <= skid_strb_q;
          tlast_q     <= skid_last_q;
          skid_v_q    <= rd_v_q;
          skid_data_q <= in_data_w;
          skid_strb_q <= in_strb_w;
          skid_last_q <= rd_last_q;
        end else if (rd_v_q) begin
          tdata_q <= in_data_w;
          tstrb_q <= in_strb_w;
          tlast_q <= rd_last_q;
        end else begin
          tvalid_q <= 1'b0;
          tlast_q  <= 1'b0;
        end
      end else if (rd_v_q) begin
        if (!tvalid_q) begin
          tvalid_q <= 1'b1;
          tdata_q  <= in_data_w;
          tstrb_q  <= in_strb_w;
          tlast_q  <= rd_last_q;
        end else begin
          skid_v_q    <= 1'b1;
          skid_data_q <= in_data_w;
          skid_strb_q <= in_strb_w;
          skid_last_q <= rd_last_q;
        end
      end

      case (state_q)
        ST_COLLECT: begin
          if (i_send_flg) begin
            beats_q <= beats_now_w;
            if (beats_now_w == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_SEND;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (pop_w && tlast_q) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_COLLECT;
          done_q   <= 1'b0;
          wr_ptr_q <= '0;
          beats_q  <= '0;
          rd_idx_q <= '0;
          cnt_q    <= 2'd0;
          pack_q   <= 24'h0;
        end
      endcase
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tstrb  = tstrb_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_err         = err_q;

endmodule
`default_nettype wire
